// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: RV32I load/store engine; byte-serialised stores, extended loads. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module load_store_unit #(
  parameter int MEM_BYTES = 8192,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_isStore,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_storeData,
  output logic              resp_valid,
  output logic [31:0]       resp_loadData,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] dataAddress,
  output logic [31:0]       writeData,
  output logic              memWrite,
  output logic              sb,
  input  logic [31:0]       data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] C_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  // Access size minus one, i.e. the index of the last byte touched.
  function automatic logic [1:0] f_last(input logic [1:0] sz);
    case (sz)
      2'b00:   f_last = 2'd0;
      2'b01:   f_last = 2'd1;
      default: f_last = 2'd3;
    endcase
  endfunction

  state_t            r_state;
  logic [1:0]        r_byteCnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_storeData;
  logic [2:0]        r_funct3;
  logic              r_ready;
  logic              r_respValid;
  logic              r_respFault;
  logic [31:0]       r_respData;
  logic [ADDR_W-1:0] r_dataAddr;
  logic [7:0]        r_wbyte;
  logic              r_memWrite;

  state_t            w_stateNxt;
  logic [1:0]        w_cntNxt;
  logic              w_accept;
  logic              w_readyNxt;
  logic [ADDR_W-1:0] w_addrNxt;
  logic [7:0]        w_wbyteNxt;
  logic              w_memWrNxt;
  logic              w_respValidNxt;
  logic              w_respFaultNxt;
  logic [31:0]       w_respDataNxt;

  logic [ADDR_W:0]   w_reqEnd;
  logic              w_badF3;
  logic              w_reqFault;
  logic [1:0]        w_last;
  logic [1:0]        w_cntInc;
  logic [7:0]        w_nextByte;
  logic [31:0]       w_ext;

  // End address carries an extra bit so a wrapping access is caught as a fault.
  assign w_reqEnd   = {1'b0, req_address} + (ADDR_W+1)'(f_last(req_funct3[1:0]));
  assign w_badF3    = (req_funct3 == 3'b011) |
                      (req_funct3[2] & (req_funct3[1] | req_isStore));
  assign w_reqFault = w_badF3 | (w_reqEnd >= C_MEM_LIMIT);

  assign w_last     = f_last(r_funct3[1:0]);
  assign w_cntInc   = r_byteCnt + 2'd1;
  assign w_nextByte = r_storeData[{w_cntInc, 3'b000} +: 8];

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{data[7]}}, data[7:0]};
      3'b100:  w_ext = {24'b0, data[7:0]};
      3'b001:  w_ext = {{16{data[15]}}, data[15:0]};
      3'b101:  w_ext = {16'b0, data[15:0]};
      default: w_ext = data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_comb begin
    w_stateNxt     = r_state;
    w_cntNxt       = r_byteCnt;
    w_accept       = 1'b0;
    w_readyNxt     = 1'b0;
    w_addrNxt      = r_dataAddr;
    w_wbyteNxt     = r_wbyte;
    w_memWrNxt     = 1'b0;
    w_respValidNxt = 1'b0;
    w_respFaultNxt = 1'b0;
    w_respDataNxt  = 32'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ready && req_valid) begin
          w_accept = 1'b1;
          w_cntNxt = 2'd0;
          if (w_reqFault) begin
            w_stateNxt     = S_RESP;
            w_respValidNxt = 1'b1;
            w_respFaultNxt = 1'b1;
          end else if (req_isStore) begin
            w_stateNxt = S_STORE;
            w_addrNxt  = req_address;
            w_wbyteNxt = req_storeData[7:0];
            w_memWrNxt = 1'b1;
          end else begin
            w_stateNxt = S_LOAD;
            w_addrNxt  = req_address;
          end
        end else begin
          w_readyNxt = 1'b1;
        end
      end
      S_LOAD: begin
        w_stateNxt     = S_RESP;
        w_respValidNxt = 1'b1;
        w_respDataNxt  = w_ext;
      end
      S_STORE: begin
        if (r_byteCnt == w_last) begin
          w_stateNxt     = S_RESP;
          w_respValidNxt = 1'b1;
        end else begin
          w_cntNxt   = w_cntInc;
          w_addrNxt  = r_addr + ADDR_W'(w_cntInc);
          w_wbyteNxt = w_nextByte;
          w_memWrNxt = 1'b1;
        end
      end
      S_RESP: begin
        w_stateNxt = S_IDLE;
        w_readyNxt = 1'b1;
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byteCnt   <= 2'd0;
      r_addr      <= '0;
      r_storeData <= 32'b0;
      r_funct3    <= 3'b0;
      r_ready     <= 1'b0;
      r_respValid <= 1'b0;
      r_respFault <= 1'b0;
      r_respData  <= 32'b0;
      r_dataAddr  <= '0;
      r_wbyte     <= 8'b0;
      r_memWrite  <= 1'b0;
    end else begin
      r_byteCnt   <= w_cntNxt;
      r_ready     <= w_readyNxt;
      r_respValid <= w_respValidNxt;
      r_respFault <= w_respFaultNxt;
      r_respData  <= w_respDataNxt;
      r_dataAddr  <= w_addrNxt;
      r_wbyte     <= w_wbyteNxt;
      r_memWrite  <= w_memWrNxt;
      if (w_accept) begin
        r_addr      <= req_address;
        r_storeData <= req_storeData;
        r_funct3    <= req_funct3;
      end
    end
  end

  assign req_ready     = r_ready;
  assign resp_valid    = r_respValid;
  assign resp_fault    = r_respFault;
  assign resp_loadData = r_respData;
  assign dataAddress   = r_dataAddr;
  assign writeData     = {24'b0, r_wbyte};
  assign memWrite      = r_memWrite;
  assign sb            = r_memWrite;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit: directed self-checking bench with a byte-array memory. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;

  localparam int MEMB = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_isStore;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_storeData;
  logic        resp_valid;
  logic [31:0] resp_loadData;
  logic        resp_fault;
  logic [31:0] dataAddress;
  logic [31:0] writeData;
  logic        memWrite;
  logic        sb;
  logic [31:0] data;

  int total = 0;
  int bad   = 0;

  bit [7:0]    pre [0:MEMB-1];
  bit [7:0]    mem [0:MEMB-1];
  bit          wrf [0:MEMB-1];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          sb_bad = 0;
  int          hi_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_isStore(req_isStore), .req_funct3(req_funct3),
    .req_address(req_address), .req_storeData(req_storeData),
    .resp_valid(resp_valid), .resp_loadData(resp_loadData), .resp_fault(resp_fault),
    .dataAddress(dataAddress), .writeData(writeData),
    .memWrite(memWrite), .sb(sb), .data(data)
  );

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (a >= MEMB) return 8'h00;
    return wrf[a[12:0]] ? mem[a[12:0]] : pre[a[12:0]];
  endfunction

  assign data = {rd(dataAddress + 32'd3), rd(dataAddress + 32'd2),
                 rd(dataAddress + 32'd1), rd(dataAddress)};

  // Memory write port plus a log of every byte write seen.
  always @(posedge clk) begin
    if (memWrite === 1'b1) begin
      if (dataAddress < MEMB) begin
        mem[dataAddress[12:0]] <= writeData[7:0];
        wrf[dataAddress[12:0]] <= 1'b1;
      end
      wr_addr_q.push_back(dataAddress);
      wr_data_q.push_back(writeData[7:0]);
      if (sb !== 1'b1) sb_bad <= sb_bad + 1;
      if (writeData[31:8] !== 24'h0) hi_bad <= hi_bad + 1;
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] ld,
                        output logic flt, output int lowc, output int nresp);
    int k;
    lat = -1; ld = 'x; flt = 1'bx; lowc = 0; nresp = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_isStore = st; req_funct3 = f3;
    req_address = a; req_storeData = d;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    // Scramble request inputs to show the latched copy is used.
    req_valid = 1'b0; req_isStore = ~st; req_funct3 = 3'b111;
    req_address = ~a; req_storeData = ~d;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        nresp++;
        if (lat < 0) begin
          lat = i; ld = resp_loadData; flt = resp_fault;
        end
      end
      if (req_ready === 1'b1) break;
      lowc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; req_isStore = 1'b0; req_funct3 = 3'b0;
    req_address = 32'h0; req_storeData = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    total++; if ({resp_valid, resp_fault, memWrite, sb} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_fault, memWrite, sb}); end
    total++; if (resp_loadData !== 32'h0) begin bad++; $display("FAIL reset_loadData got=%h exp=0", resp_loadData); end
    total++; if ({dataAddress, writeData} !== 64'h0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", dataAddress, writeData); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_idle got=%b exp=1", req_ready); end
  endtask

  task automatic test_lw_basic();
    int lat, lowc, nr; logic [31:0] ld; logic flt;
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, ld, flt, lowc, nr);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (lowc !== 2) begin bad++; $display("FAIL lw_ready_low got=%0d exp=2", lowc); end
    total++; if (ld !== 32'h0000_0001) begin bad++; $display("FAIL lw_data got=%h exp=00000001", ld); end
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL lw_fault got=%b exp=0", flt); end
    total++; if (nr !== 1) begin bad++; $display("FAIL lw_nresp got=%0d exp=1", nr); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3[5];
    logic [31:0] ad[5];
    logic [31:0] ex[5];
    int lat, lowc, nr; logic [31:0] ld; logic flt;
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ad = '{32'h5, 32'h5, 32'h6, 32'h6, 32'h1FFC};
    ex = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_F000, 32'h0000_F000, 32'h4433_2211};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, lat, ld, flt, lowc, nr);
      total++; if (ld !== ex[i] || flt !== 1'b0) begin bad++; $display("FAIL load_ext[%0d] got=%h/%b exp=%h/0", i, ld, flt, ex[i]); end
    end
  endtask

  task automatic test_store_sw();
    logic [31:0] ea[4];
    logic [7:0]  ed[4];
    int lat, lowc, nr; logic [31:0] ld; logic flt;
    ea = '{32'h101, 32'h102, 32'h103, 32'h104};
    ed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_req(1'b1, 3'b010, 32'h101, 32'hDEAD_BEEF, lat, ld, flt, lowc, nr);
    total++; if (lat !== 5) begin bad++; $display("FAIL sw_latency got=%0d exp=5", lat); end
    total++; if (ld !== 32'h0 || flt !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%b exp=0/0", ld, flt); end
    total++; if (wr_addr_q.size() !== 4) begin bad++; $display("FAIL sw_nwrites got=%0d exp=4", wr_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin bad++; $display("FAIL sw_byte[%0d] got=%h:%h exp=%h:%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]); end
    end
    total++; if (sb_bad !== 0 || hi_bad !== 0) begin bad++; $display("FAIL sw_sb_upper got=%0d/%0d exp=0/0", sb_bad, hi_bad); end
    do_req(1'b0, 3'b010, 32'h101, 32'h0, lat, ld, flt, lowc, nr);
    total++; if (ld !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_readback got=%h exp=deadbeef", ld); end
  endtask

  task automatic test_store_sh_sb();
    int lat, lowc, nr; logic [31:0] ld; logic flt;
    do_req(1'b1, 3'b001, 32'h20, 32'h1234_5678, lat, ld, flt, lowc, nr);
    total++; if (lat !== 3) begin bad++; $display("FAIL sh_latency got=%0d exp=3", lat); end
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL sh_nwrites got=%0d exp=2", wr_addr_q.size()); end
    total++; if (wr_data_q[0] !== 8'h78 || wr_data_q[1] !== 8'h56) begin bad++; $display("FAIL sh_bytes got=%h,%h exp=78,56", wr_data_q[0], wr_data_q[1]); end
    total++; if (rd(32'h22) !== 8'hAA) begin bad++; $display("FAIL sh_untouched got=%h exp=aa", rd(32'h22)); end
    do_req(1'b1, 3'b000, 32'h30, 32'hFFFF_FFA5, lat, ld, flt, lowc, nr);
    total++; if (lat !== 2 || wr_addr_q.size() !== 1) begin bad++; $display("FAIL sb_latency got=%0d/%0d exp=2/1", lat, wr_addr_q.size()); end
    total++; if (rd(32'h30) !== 8'hA5 || rd(32'h31) !== 8'h00) begin bad++; $display("FAIL sb_mem got=%h,%h exp=a5,00", rd(32'h30), rd(32'h31)); end
  endtask

  task automatic test_faults();
    logic        st[4];
    logic [2:0]  f3[4];
    logic [31:0] ad[4];
    int lat, lowc, nr; logic [31:0] ld; logic flt;
    st = '{1'b0, 1'b0, 1'b1, 1'b0};
    f3 = '{3'b010, 3'b011, 3'b100, 3'b010};
    ad = '{32'h1FFE, 32'h40, 32'h40, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      do_req(st[i], f3[i], ad[i], 32'hCAFE_F00D, lat, ld, flt, lowc, nr);
      total++; if (flt !== 1'b1 || lat !== 1) begin bad++; $display("FAIL fault[%0d] got=%b lat=%0d exp=1 lat=1", i, flt, lat); end
      total++; if (wr_addr_q.size() !== 0 || ld !== 32'h0) begin bad++; $display("FAIL fault_effect[%0d] got=%0d/%h exp=0/0", i, wr_addr_q.size(), ld); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, rsp;
    logic [31:0] last;
    acc = 0; rsp = 0; last = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_isStore = 1'b0; req_funct3 = 3'b010; req_address = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) acc++;
      if (resp_valid === 1'b1) begin rsp++; last = resp_loadData; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1) begin rsp++; last = resp_loadData; end
      @(negedge clk);
    end
    total++; if (acc !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
    total++; if (rsp !== 4) begin bad++; $display("FAIL b2b_responses got=%0d exp=4", rsp); end
    total++; if (last !== 32'h1) begin bad++; $display("FAIL b2b_data got=%h exp=00000001", last); end
  endtask

  task automatic test_reset_mid_store();
    int rsp, k;
    rsp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_isStore = 1'b1; req_funct3 = 3'b010;
    req_address = 32'h200; req_storeData = 32'h1122_3344;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (memWrite !== 1'b1 || dataAddress !== 32'h202) begin bad++; $display("FAIL midrst_third_byte got=%b@%h exp=1@00000202", memWrite, dataAddress); end
    rst_n = 1'b0;
    #1;
    total++; if (memWrite !== 1'b0 || sb !== 1'b0) begin bad++; $display("FAIL midrst_memwrite got=%b/%b exp=0/0", memWrite, sb); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) rsp++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) rsp++;
    end
    total++; if (rsp !== 0) begin bad++; $display("FAIL midrst_no_resp got=%0d exp=0", rsp); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    total++; if ({rd(32'h200), rd(32'h201), rd(32'h202)} !== 24'h44_33_00) begin bad++; $display("FAIL midrst_mem got=%h exp=443300", {rd(32'h200), rd(32'h201), rd(32'h202)}); end
  endtask

  initial begin
    pre[0]      = 8'h01;
    pre[5]      = 8'hF0;
    pre[6]      = 8'h00;
    pre[7]      = 8'hF0;
    pre[32'h22] = 8'hAA;
    pre[13'h1FFC] = 8'h11;
    pre[13'h1FFD] = 8'h22;
    pre[13'h1FFE] = 8'h33;
    pre[13'h1FFF] = 8'h44;
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_store_sw();
    test_store_sh_sb();
    test_faults();
    test_back_to_back();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
